mem_port_arbiter: RTL and testbench

- Shares one burst memory port between two IO memory-mapped requesters, e.g. two 16-bit IOMM bridges (CPU side plus DMA/programmer side).
- Grants whole bursts: a grant is held from request issue through the last data beat.
- Fairness is round-robin by default.
- Sits between the requesters' memory interfaces and the SDRAM/SRAM controller.

---
 rtl/mem_port_arbiter_if.sv | 83 ++++++++
 rtl/mem_port_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose:
//   Bundles every bus signal around mem_port_arbiter. That covers the two
//   requester burst ports (p0_*, p1_*) and the single port toward the
//   SDRAM/SRAM controller (mem_*).
//
// Modports:
//   slave  - the arbiter's view. It reads the requester requests and the
//            controller responses, and drives the requester responses and
//            the controller request.
//   master - the surrounding system's view (requesters plus controller).
//            Every direction is the reverse of the slave modport.
//
// Signal summary (per requester port pX, X = 0/1):
//   pX_address  [31:0]  burst address          requester -> arbiter
//   pX_to_mem   [15:0]  write data             requester -> arbiter
//   pX_req              request level          requester -> arbiter
//   pX_wren             write burst when 1     requester -> arbiter
//   pX_from_mem [15:0]  read data              arbiter   -> requester
//   pX_ready            request accepted pulse arbiter   -> requester
//   pX_valid            beat strobe            arbiter   -> requester
//   pX_offset   [2:0]   beat index             arbiter   -> requester
// Controller side:
//   mem_address [31:0], mem_to_mem [15:0], mem_req, mem_wren  arbiter -> ctrl
//   mem_from_mem [15:0], mem_ready, mem_valid, mem_offset [2:0] ctrl -> arbiter
// -----------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if;

    // Requester port 0
    logic [31:0] p0_address;
    logic [15:0] p0_to_mem;
    logic        p0_req;
    logic        p0_wren;
    logic [15:0] p0_from_mem;
    logic        p0_ready;
    logic        p0_valid;
    logic [2:0]  p0_offset;

    // Requester port 1
    logic [31:0] p1_address;
    logic [15:0] p1_to_mem;
    logic        p1_req;
    logic        p1_wren;
    logic [15:0] p1_from_mem;
    logic        p1_ready;
    logic        p1_valid;
    logic [2:0]  p1_offset;

    // Memory controller port
    logic [31:0] mem_address;
    logic [15:0] mem_to_mem;
    logic [15:0] mem_from_mem;
    logic        mem_req;
    logic        mem_wren;
    logic        mem_ready;
    logic        mem_valid;
    logic [2:0]  mem_offset;

    modport slave (
        input  p0_address, p0_to_mem, p0_req, p0_wren,
        output p0_from_mem, p0_ready, p0_valid, p0_offset,
        input  p1_address, p1_to_mem, p1_req, p1_wren,
        output p1_from_mem, p1_ready, p1_valid, p1_offset,
        output mem_address, mem_to_mem, mem_req, mem_wren,
        input  mem_from_mem, mem_ready, mem_valid, mem_offset
    );

    modport master (
        output p0_address, p0_to_mem, p0_req, p0_wren,
        input  p0_from_mem, p0_ready, p0_valid, p0_offset,
        output p1_address, p1_to_mem, p1_req, p1_wren,
        input  p1_from_mem, p1_ready, p1_valid, p1_offset,
        input  mem_address, mem_to_mem, mem_req, mem_wren,
        output mem_from_mem, mem_ready, mem_valid, mem_offset
    );

endinterface : mem_port_arbiter_if

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one burst memory port between two memory-mapped requesters, for
//   example a CPU-side bridge and a DMA/programmer-side bridge. A grant
//   covers a whole burst. It is held from request issue through the last
//   data beat, so the controller only ever sees one owner per burst.
//
// Arbitration:
//   Default build : round-robin. On a tie, the port that did not win last
//                   time gets the grant. After reset, port 0 wins the
//                   first tie.
//   MEM_ARB_PRIO0_EN defined : fixed priority. Port 0 wins every tie, and
//                   port 1 is only served when p0_req is low in the IDLE
//                   sample cycle. Everything else is identical.
//
// Timing:
//   IDLE  - sample both requests and register a one-hot grant. There is no
//           combinational path from a request to the grant.
//   ISSUE - present the owner's request to the controller. The owner's
//           ready is the controller's ready, in the same cycle. If the
//           owner withdraws its request first, the arbiter falls back to
//           IDLE without starting a burst.
//   BURST - forward beat strobes to the owner only, and count them. After
//           the BURST_LENGTH-th beat, the next cycle is IDLE.
//
// Parameters:
//   BURST_LENGTH  beats per burst, 1..8 (default 8)
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    mem_port_arbiter_if.slave (requester ports + controller port)
//   grant  [1:0] one-hot current owner, 00 when idle
//   busy   high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
    parameter int unsigned BURST_LENGTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    mem_port_arbiter_if.slave        bus,
    output logic [1:0]               grant,
    output logic                     busy
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter guard
    // -------------------------------------------------------------------------
    if (BURST_LENGTH < 1 || BURST_LENGTH > 8) begin : g_bad_burst_length
        $error("mem_port_arbiter: BURST_LENGTH must be in 1..8");
    end

    // The beat counter has one more bit than the 3-bit offset. That lets it
    // reach 8 without wrapping inside a burst.
    localparam logic [3:0] LP_BURST_LEN = 4'(BURST_LENGTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic [1:0]  r_grant;
    logic        r_busy;
    logic [3:0]  r_beat_cnt;
`ifndef MEM_ARB_PRIO0_EN
    logic        r_last_grant;   // 1 = port 1 owned the last completed issue
`endif

    // -------------------------------------------------------------------------
    // Decodes
    // -------------------------------------------------------------------------
    logic        w_issue;
    logic        w_burst;
    logic        w_own_req;
    logic        w_pick_p1;
    logic [3:0]  w_cnt_next;
    logic        w_last_beat;

    assign w_issue     = (r_state == ST_ISSUE);
    assign w_burst     = (r_state == ST_BURST);

    // The request of whichever port currently holds the grant.
    assign w_own_req   = (r_grant[0] & bus.p0_req) | (r_grant[1] & bus.p1_req);

    assign w_cnt_next  = r_beat_cnt + 4'd1;
    assign w_last_beat = bus.mem_valid && (w_cnt_next == LP_BURST_LEN);

    // Choose port 1 in IDLE. Port 0 is the fallback whenever any request
    // is present and this is low.
`ifdef MEM_ARB_PRIO0_EN
    assign w_pick_p1 = bus.p1_req & ~bus.p0_req;
`else
    assign w_pick_p1 = bus.p1_req & (~bus.p0_req | ~r_last_grant);
`endif

    // -------------------------------------------------------------------------
    // FSM: state, grant, busy and beat counter, all registered together
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'b00;
            r_busy       <= 1'b0;
            r_beat_cnt   <= 4'd0;
`ifndef MEM_ARB_PRIO0_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.p0_req || bus.p1_req) begin
                        r_grant <= w_pick_p1 ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (!w_own_req) begin
                        // Requester flushed before acceptance. Nothing was
                        // issued, so fairness history is left untouched.
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (bus.mem_ready) begin
                        r_beat_cnt   <= 4'd0;
`ifndef MEM_ARB_PRIO0_EN
                        r_last_grant <= r_grant[1];
`endif
                        r_state      <= ST_BURST;
                    end
                end

                ST_BURST: begin
                    if (bus.mem_valid) begin
                        r_beat_cnt <= w_cnt_next;
                    end
                    if (w_last_beat) begin
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;

    // -------------------------------------------------------------------------
    // Port steering
    //   Address, write enable and write data follow the owner. They are held
    //   at zero while nobody owns the port. Write data is steered
    //   combinationally, so a requester popping its write buffer on pX_valid
    //   stays aligned with the controller consuming the beat.
    //   Strobes reach only the owner, and only in the state where they are
    //   meaningful. A stray mem_valid in IDLE/ISSUE is therefore dropped.
    // -------------------------------------------------------------------------
    // NOTE: every output gets a default before the case logic, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        bus.mem_address = 32'd0;
        bus.mem_wren    = 1'b0;
        bus.mem_to_mem  = 16'd0;

        if (r_grant[0]) begin
            bus.mem_address = bus.p0_address;
            bus.mem_wren    = bus.p0_wren;
            bus.mem_to_mem  = bus.p0_to_mem;
        end else if (r_grant[1]) begin
            bus.mem_address = bus.p1_address;
            bus.mem_wren    = bus.p1_wren;
            bus.mem_to_mem  = bus.p1_to_mem;
        end

        bus.mem_req     = w_issue & w_own_req;

        bus.p0_ready    = w_issue & r_grant[0] & bus.mem_ready;
        bus.p1_ready    = w_issue & r_grant[1] & bus.mem_ready;

        bus.p0_valid    = w_burst & r_grant[0] & bus.mem_valid;
        bus.p1_valid    = w_burst & r_grant[1] & bus.mem_valid;

        bus.p0_offset   = bus.p0_valid ? bus.mem_offset : 3'd0;
        bus.p1_offset   = bus.p1_valid ? bus.mem_offset : 3'd0;

        // Read data goes to both ports. It is qualified by each port's own
        // valid, and it is quiet outside a burst.
        bus.p0_from_mem = w_burst ? bus.mem_from_mem : 16'd0;
        bus.p1_from_mem = w_burst ? bus.mem_from_mem : 16'd0;
    end

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int BL = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant;
    logic       busy;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.BURST_LENGTH(BL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        port;
        logic [2:0]  off;
        logic [15:0] data;
    } beat_t;

    beat_t sb_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are driven and outputs sampled 2 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic p, input logic v);
        if (p) bus.p1_req = v;
        else   bus.p0_req = v;
    endtask

    task automatic wait_mem_req(input logic p, input logic wr, input logic [31:0] addr);
        int n;
        n = 0;
        while (!bus.mem_req && n < 16) begin
            step();
            n++;
        end
        check("mem_req_seen", bus.mem_req, 1);
        check("mem_address", bus.mem_address, addr);
        check("mem_wren", bus.mem_wren, wr);
        check("grant_issue", grant, p ? 2'b10 : 2'b01);
        check("busy_issue", busy, 1);
    endtask

    task automatic accept(input logic p, input logic drop);
        bus.mem_ready = 1'b1;
        #1;
        check("ready_own", p ? bus.p1_ready : bus.p0_ready, 1);
        check("ready_other", p ? bus.p0_ready : bus.p1_ready, 0);
        step();
        bus.mem_ready = 1'b0;
        if (drop) set_req(p, 1'b0);
    endtask

    task automatic idle_beat();
        bus.mem_valid = 1'b0;
        #1;
        check("gap_p0_valid", bus.p0_valid, 0);
        check("gap_p1_valid", bus.p1_valid, 0);
        step();
    endtask

    task automatic beat(input logic p, input logic wr, input int k);
        beat_t       e;
        logic [15:0] d;
        logic        own_v;
        logic        oth_v;
        logic [2:0]  got_off;
        logic [15:0] got_d;
        if (wr) begin
            d = (p ? 16'hA000 : 16'h5000) + 16'(k);
            if (p) begin
                bus.p1_to_mem = d;
                bus.p0_to_mem = 16'($urandom);
            end else begin
                bus.p0_to_mem = d;
                bus.p1_to_mem = 16'($urandom);
            end
        end else begin
            d = 16'($urandom_range(0, 65535));
            bus.mem_from_mem = d;
        end
        bus.mem_valid  = 1'b1;
        bus.mem_offset = 3'(k);
        sb_q.push_back(beat_t'{port: p, off: 3'(k), data: d});
        #1;
        own_v = p ? bus.p1_valid : bus.p0_valid;
        oth_v = p ? bus.p0_valid : bus.p1_valid;
        check("busy_in_burst", busy, 1);
        check("valid_own", own_v, 1);
        check("valid_other", oth_v, 0);
        check("offset_other", p ? bus.p0_offset : bus.p1_offset, 0);
        if (!wr) check("from_mem_other", p ? bus.p0_from_mem : bus.p1_from_mem, d);
        if (own_v || oth_v) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e       = sb_q.pop_front();
                got_off = bus.p0_valid ? bus.p0_offset : bus.p1_offset;
                got_d   = wr ? bus.mem_to_mem
                             : (bus.p0_valid ? bus.p0_from_mem : bus.p1_from_mem);
                check("beat_port", bus.p1_valid, e.port);
                check("beat_offset", got_off, e.off);
                check("beat_data", got_d, e.data);
            end
        end
        step();
        bus.mem_valid = 1'b0;
    endtask

    task automatic finish_check();
        #1;
        check("busy_after", busy, 0);
        check("grant_after", grant, 0);
        check("mem_req_gap", bus.mem_req, 0);
        check("addr_idle", bus.mem_address, 0);
        check("wren_idle", bus.mem_wren, 0);
        check("to_mem_idle", bus.mem_to_mem, 0);
        check("sb_empty", sb_q.size(), 0);
    endtask

    task automatic serve(input logic p, input logic wr, input logic [31:0] addr, input logic drop);
        wait_mem_req(p, wr, addr);
        accept(p, drop);
        for (int k = 0; k < BL; k++) begin
            if (k == 3) idle_beat();
            beat(p, wr, k);
        end
        finish_check();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.p0_address   = '0; bus.p0_to_mem = '0; bus.p0_req = 1'b0; bus.p0_wren = 1'b0;
        bus.p1_address   = '0; bus.p1_to_mem = '0; bus.p1_req = 1'b0; bus.p1_wren = 1'b0;
        bus.mem_from_mem = 16'h1234;
        bus.mem_ready    = 1'b0;
        bus.mem_valid    = 1'b1;
        bus.mem_offset   = 3'd5;
        reset            = 1'b1;
        step();
        step();

        // Reset state: controller noise must not reach any output.
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_p0_valid", bus.p0_valid, 0);
        check("rst_p1_valid", bus.p1_valid, 0);
        check("rst_p0_offset", bus.p0_offset, 0);
        check("rst_p0_from_mem", bus.p0_from_mem, 0);
        check("rst_mem_address", bus.mem_address, 0);
        bus.mem_valid    = 1'b0;
        bus.mem_offset   = 3'd0;
        bus.mem_from_mem = 16'd0;
        reset            = 1'b0;
        step();

        // Single port 0 read burst.
        bus.p0_address = 32'h0000_1000;
        bus.p0_wren    = 1'b0;
        bus.p0_req     = 1'b1;
        #1;
        check("req_latency", bus.mem_req, 0);
        check("idle_busy", busy, 0);
        step();
        check("mem_req_next_cycle", bus.mem_req, 1);
        serve(1'b0, 1'b0, 32'h0000_1000, 1'b1);

        // Both ports requesting continuously.
        do_reset();
        bus.p0_address = 32'h0000_2000; bus.p0_wren = 1'b0;
        bus.p1_address = 32'h0000_3000; bus.p1_wren = 1'b1;
        bus.p0_req = 1'b1;
        bus.p1_req = 1'b1;
        step();
`ifdef MEM_ARB_PRIO0_EN
        serve(1'b0, 1'b0, 32'h0000_2000, 1'b0);
        serve(1'b0, 1'b0, 32'h0000_2000, 1'b0);
        serve(1'b0, 1'b0, 32'h0000_2000, 1'b0);
        bus.p0_req = 1'b0;
        serve(1'b1, 1'b1, 32'h0000_3000, 1'b1);
`else
        serve(1'b0, 1'b0, 32'h0000_2000, 1'b0);
        serve(1'b1, 1'b1, 32'h0000_3000, 1'b0);
        serve(1'b0, 1'b0, 32'h0000_2000, 1'b0);
        serve(1'b1, 1'b1, 32'h0000_3000, 1'b0);
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
`endif
        step();

        // Port 1 write burst with port 0 data toggling in the background.
        bus.p1_address = 32'h0000_4000;
        bus.p1_wren    = 1'b1;
        bus.p1_req     = 1'b1;
        step();
        serve(1'b1, 1'b1, 32'h0000_4000, 1'b1);
        step();

        // Port 1 flushes its request in ISSUE, and a pending port 0 is
        // served next. Stray mem_valid in ISSUE/IDLE must be ignored.
        bus.p1_address = 32'h0000_6000;
        bus.p1_wren    = 1'b0;
        bus.p1_req     = 1'b1;
        step();
        check("flush_grant", grant, 2'b10);
        check("flush_mem_req", bus.mem_req, 1);
        bus.p1_req     = 1'b0;
        bus.p0_address = 32'h0000_5000;
        bus.p0_wren    = 1'b0;
        bus.p0_req     = 1'b1;
        bus.mem_valid  = 1'b1;
        #1;
        check("flush_req_drop", bus.mem_req, 0);
        check("flush_p0_ready", bus.p0_ready, 0);
        check("stray_valid_issue", bus.p1_valid, 0);
        step();
        check("flush_idle_busy", busy, 0);
        check("flush_idle_grant", grant, 0);
        check("stray_valid_idle_p0", bus.p0_valid, 0);
        check("stray_valid_idle_p1", bus.p1_valid, 0);
        bus.mem_valid = 1'b0;
        serve(1'b0, 1'b0, 32'h0000_5000, 1'b1);
        step();

        // Reset during beat 4 of a port 0 read.
        bus.p0_address = 32'h0000_7000;
        bus.p0_wren    = 1'b0;
        bus.p0_req     = 1'b1;
        step();
        wait_mem_req(1'b0, 1'b0, 32'h0000_7000);
        accept(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) beat(1'b0, 1'b0, k);
        bus.mem_valid    = 1'b1;
        bus.mem_offset   = 3'd3;
        bus.mem_from_mem = 16'hBEEF;
        #1;
        check("pre_reset_valid", bus.p0_valid, 1);
        reset = 1'b1;
        #1;
        check("midrst_grant", grant, 0);
        check("midrst_busy", busy, 0);
        check("midrst_p0_valid", bus.p0_valid, 0);
        check("midrst_p0_offset", bus.p0_offset, 0);
        sb_q.delete();
        step();
        bus.mem_valid  = 1'b0;
        bus.mem_offset = 3'd0;
        reset          = 1'b0;
        step();
        bus.p1_address = 32'h0000_8000;
        bus.p1_wren    = 1'b0;
        bus.p1_req     = 1'b1;
        step();
        serve(1'b1, 1'b0, 32'h0000_8000, 1'b1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_port_arbiter
